// File: rtl/matmul_mem_arbiter_if.sv
// Request/grant and RAM-side signal bundle for matmul_mem_arbiter.
// master: requesters + RAM (drive requests and read data)
// slave:  the arbiter (drives grants, responses and the RAM command)
interface matmul_mem_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_wr_en;
    logic [NUM_REQ*DATA_W-1:0] req_wr_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]         rd_data;
    logic                      busy;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_wr_en;
    logic [DATA_W-1:0]         mem_wr_data;
    logic [DATA_W-1:0]         mem_rd_data;

    modport master (
        output req, req_addr, req_wr_en, req_wr_data, mem_rd_data,
        input  gnt, rd_valid, rd_data, busy, mem_addr, mem_wr_en, mem_wr_data
    );

    modport slave (
        input  req, req_addr, req_wr_en, req_wr_data, mem_rd_data,
        output gnt, rd_valid, rd_data, busy, mem_addr, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/matmul_mem_arbiter.sv
// Single-port matrix RAM arbiter shared by NUM_REQ requesters
// (0: STW/BIST, 1: matmul sequencer reads, 2: output writeback).
// One access per clock; read responses are routed back to their issuer
// through a tag pipeline matched to MEM_ACCESS_LATENCY.
// Optional macro MEM_ARB_FIXED_PRIO0_EN: requester 0 gets strict priority
// over the round-robin among the others.
module matmul_mem_arbiter #(
    parameter int NUM_REQ            = 3,
    parameter int ADDR_W             = 32,
    parameter int DATA_W             = 64,
    parameter int MEM_ACCESS_LATENCY = 2
) (
    input logic                 clk,
    input logic                 rst,
    matmul_mem_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int NSTG = MEM_ACCESS_LATENCY + 1;

    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_rd_valid;
    logic [DATA_W-1:0]  r_rd_data;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_wr_en;
    logic [DATA_W-1:0]  r_mem_wr_data;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [NSTG-1:0]    r_tag_vld;
    logic [ID_W-1:0]    r_tag_id [NSTG];

    logic [NUM_REQ-1:0] w_eligible;
    logic               w_found;
    logic [ID_W-1:0]    w_k;
    logic               w_upd_rr;
    logic [ID_W-1:0]    w_rr_nxt;
    logic               w_issue_rd;

    // Pick the winner: first eligible requester at or after rr_ptr (wrapping).
    always_comb begin
        logic [ID_W-1:0] v_idx;
        v_idx      = '0;
        w_eligible = bus.req & ~r_gnt;
        w_found    = 1'b0;
        w_k        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            v_idx = ID_W'((32'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_found && w_eligible[v_idx]) begin
                w_found = 1'b1;
                w_k     = v_idx;
            end
        end
        w_upd_rr = w_found;
`ifdef MEM_ARB_FIXED_PRIO0_EN
        // Requester 0 overrides the rotation and leaves rr_ptr untouched.
        if (w_eligible[0]) begin
            w_found  = 1'b1;
            w_k      = '0;
            w_upd_rr = 1'b0;
        end
`endif
        w_rr_nxt   = ID_W'((32'(w_k) + 32'd1) % NUM_REQ);
        w_issue_rd = w_found & ~bus.req_wr_en[w_k];
    end

    // Register the grant pulse and the RAM command for the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt         <= '0;
            r_mem_addr    <= '0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_data <= '0;
            r_rr_ptr      <= '0;
        end else begin
            r_gnt       <= '0;
            r_mem_wr_en <= 1'b0;
            if (w_found) begin
                r_gnt[w_k]    <= 1'b1;
                r_mem_addr    <= bus.req_addr[32'(w_k)*ADDR_W +: ADDR_W];
                r_mem_wr_en   <= bus.req_wr_en[w_k];
                r_mem_wr_data <= bus.req_wr_data[32'(w_k)*DATA_W +: DATA_W];
                if (w_upd_rr) begin
                    r_rr_ptr <= w_rr_nxt;
                end
            end
        end
    end

    // Tag pipeline: stage j describes the access presented j cycles ago,
    // so the last stage lines up with the cycle mem_rd_data is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= '0;
            for (int unsigned j = 0; j < NSTG; j++) begin
                r_tag_id[j] <= '0;
            end
        end else begin
            r_tag_vld   <= {r_tag_vld[NSTG-2:0], w_issue_rd};
            r_tag_id[0] <= w_k;
            for (int unsigned j = 1; j < NSTG; j++) begin
                r_tag_id[j] <= r_tag_id[j-1];
            end
        end
    end

    // Capture read data and pulse rd_valid for the issuing requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= '0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= '0;
            if (r_tag_vld[NSTG-1]) begin
                r_rd_valid[r_tag_id[NSTG-1]] <= 1'b1;
                r_rd_data                    <= bus.mem_rd_data;
            end
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.rd_data     = r_rd_data;
    assign bus.busy        = |r_tag_vld;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wr_en   = r_mem_wr_en;
    assign bus.mem_wr_data = r_mem_wr_data;

endmodule
